// File: rtl/ball_position_tracker_if.sv
// Purpose : wall-ROM read handshake between the ball tracker (master) and the maze map ROM (slave).
// Latency : request is a single-cycle map_rd strobe; the response arrives on map_valid any number of cycles later.
// Backpr. : no backpressure; the master gives up after its own timeout if map_valid never arrives.
// Ports   : map_rd/map_addr (master -> ROM), map_valid/map_data (ROM -> master, map_data 1 = wall).
interface ball_position_tracker_if;
    logic       map_rd;
    logic [7:0] map_addr;
    logic       map_valid;
    logic       map_data;

    modport master (
        output map_rd,
        output map_addr,
        input  map_valid,
        input  map_data
    );

    modport slave (
        input  map_rd,
        input  map_addr,
        output map_valid,
        output map_data
    );
endinterface

// File: rtl/ball_position_tracker.sv
// Purpose : turns 4-bit move pulses into one-cell ball steps on a 16x16 maze, checking each target cell in the wall ROM.
// Latency : single axis with a 1-cycle ROM: pulse sampled at T0, map_rd in T0, position updates at edge T3, moved in T3, idle at T4.
// Backpr. : pulses are only sampled while idle (busy low); anything arriving while busy is dropped.
// Ports   : clk, reset (async active-low), move_pulses {y_inc,y_dec,x_inc,x_dec}, restart (sync),
//           rom (map read handshake, master side), x_pos/y_pos, moved, goal_reached, busy, move_count.
module ball_position_tracker #(
    parameter logic [3:0]  START_X     = 4'd0,
    parameter logic [3:0]  START_Y     = 4'd0,
    parameter logic [3:0]  GOAL_X      = 4'd15,
    parameter logic [3:0]  GOAL_Y      = 4'd15,
    parameter int unsigned MAP_TIMEOUT = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [3:0]                    move_pulses,
    input  logic                          restart,
    ball_position_tracker_if.master       rom,
    output logic [3:0]                    x_pos,
    output logic [3:0]                    y_pos,
    output logic                          moved,
    output logic                          goal_reached,
    output logic                          busy,
    output logic [15:0]                   move_count
);

    // Last timeout-counter value before the target is treated as a wall,
    // so a WAIT state lasts exactly MAP_TIMEOUT cycles without a response.
    localparam logic [7:0] TMO_LAST = 8'(MAP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_X  = 3'd1,
        WAIT_X = 3'd2,
        REQ_Y  = 3'd3,
        WAIT_Y = 3'd4,
        FINISH = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  x_q, x_d, y_q, y_d;
    logic [3:0]  x0_q, x0_d, y0_q, y0_d;      // position sampled in IDLE
    logic        xreq_q, xreq_d, xinc_q, xinc_d;
    logic        yreq_q, yreq_d, yinc_q, yinc_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        goal_q, goal_d;
    logic [15:0] count_q, count_d;

    logic        x_inc_req, x_dec_req, y_inc_req, y_dec_req;
    logic        x_ok, y_ok;
    logic [3:0]  cand_x, cand_y;
    logic [7:0]  cand_addr;
    logic        rsp_done, rsp_open, pos_changed;

    // Request decode; a request pointing off the grid never reaches the ROM.
    always_comb begin
        x_inc_req = move_pulses[1] & ~move_pulses[0];
        x_dec_req = move_pulses[0] & ~move_pulses[1];
        y_inc_req = move_pulses[3] & ~move_pulses[2];
        y_dec_req = move_pulses[2] & ~move_pulses[3];
        x_ok      = ~goal_q & ((x_inc_req & (x_q != 4'd15)) | (x_dec_req & (x_q != 4'd0)));
        y_ok      = ~goal_q & ((y_inc_req & (y_q != 4'd15)) | (y_dec_req & (y_q != 4'd0)));
    end

    // Candidates are built from the live position, so the y check sees the
    // x result of a diagonal move.
    always_comb begin
        cand_x      = xinc_q ? (x_q + 4'd1) : (x_q - 4'd1);
        cand_y      = yinc_q ? (y_q + 4'd1) : (y_q - 4'd1);
        cand_addr   = (state_q == REQ_X) ? {y_q, cand_x} : {cand_y, x_q};
        rsp_done    = rom.map_valid | (tmo_q == TMO_LAST);
        rsp_open    = rom.map_valid & ~rom.map_data;
        pos_changed = (x_q != x0_q) | (y_q != y0_q);
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (x_ok) begin
                    state_d = REQ_X;
                end else if (y_ok) begin
                    state_d = REQ_Y;
                end
            end
            REQ_X:  state_d = WAIT_X;
            WAIT_X: begin
                if (rsp_done) begin
                    state_d = yreq_q ? REQ_Y : FINISH;
                end
            end
            REQ_Y:  state_d = WAIT_Y;
            WAIT_Y: begin
                if (rsp_done) begin
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (restart) begin
            state_d = IDLE;
        end
    end

    // Output logic
    always_comb begin
        rom.map_rd   = (state_q == REQ_X) | (state_q == REQ_Y);
        rom.map_addr = rom.map_rd ? cand_addr : addr_q;
        busy         = (state_q != IDLE);
        moved        = (state_q == FINISH) & pos_changed;
    end

    // Datapath next-state
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        xreq_d  = xreq_q;
        xinc_d  = xinc_q;
        yreq_d  = yreq_q;
        yinc_d  = yinc_q;
        addr_d  = addr_q;
        tmo_d   = tmo_q;
        goal_d  = goal_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                x0_d   = x_q;
                y0_d   = y_q;
                xreq_d = x_ok;
                xinc_d = x_inc_req;
                yreq_d = y_ok;
                yinc_d = y_inc_req;
            end
            REQ_X, REQ_Y: begin
                addr_d = cand_addr;
                tmo_d  = 8'd0;
            end
            WAIT_X: begin
                tmo_d = tmo_q + 8'd1;
                if (rsp_open) begin
                    x_d = cand_x;
                end
            end
            WAIT_Y: begin
                tmo_d = tmo_q + 8'd1;
                if (rsp_open) begin
                    y_d = cand_y;
                end
            end
            FINISH: begin
                if (pos_changed && (count_q != 16'hFFFF)) begin
                    count_d = count_q + 16'd1;
                end
                if ((x_q == GOAL_X) && (y_q == GOAL_Y)) begin
                    goal_d = 1'b1;
                end
            end
            default: ;
        endcase
        if (restart) begin
            x_d     = START_X;
            y_d     = START_Y;
            addr_d  = 8'd0;
            goal_d  = 1'b0;
            count_d = 16'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q     <= START_X;
            y_q     <= START_Y;
            x0_q    <= START_X;
            y0_q    <= START_Y;
            xreq_q  <= 1'b0;
            xinc_q  <= 1'b0;
            yreq_q  <= 1'b0;
            yinc_q  <= 1'b0;
            addr_q  <= 8'd0;
            tmo_q   <= 8'd0;
            goal_q  <= 1'b0;
            count_q <= 16'd0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            xreq_q  <= xreq_d;
            xinc_q  <= xinc_d;
            yreq_q  <= yreq_d;
            yinc_q  <= yinc_d;
            addr_q  <= addr_d;
            tmo_q   <= tmo_d;
            goal_q  <= goal_d;
            count_q <= count_d;
        end
    end

    assign x_pos        = x_q;
    assign y_pos        = y_q;
    assign goal_reached = goal_q;
    assign move_count   = count_q;

endmodule

// File: tb/tb_ball_position_tracker.sv
module tb_ball_position_tracker;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        restart;
    logic [3:0]  move_pulses;
    logic [3:0]  x_pos, y_pos;
    logic        moved, goal_reached, busy;
    logic [15:0] move_count;

    ball_position_tracker_if rif ();

    ball_position_tracker #(.MAP_TIMEOUT(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .move_pulses  (move_pulses),
        .restart      (restart),
        .rom          (rif),
        .x_pos        (x_pos),
        .y_pos        (y_pos),
        .moved        (moved),
        .goal_reached (goal_reached),
        .busy         (busy),
        .move_count   (move_count)
    );

    always #5 clk = ~clk;

    // Maze and ROM behaviour
    bit          walls [256];
    bit          rom_mute;
    int          rom_delay;

    // Reference model state
    int          m_x, m_y, m_cnt;
    bit          m_goal, m_moved;
    logic [7:0]  exp_q [$];

    // Observed activity
    logic [7:0]  rd_log [$];
    int          mv_cnt;
    bit          busy_seen;

    int          tests = 0;
    int          fails = 0;

    // ROM responder plus activity monitor, all sampled 1 time unit after the edge.
    initial begin : rom_and_monitor
        int         cnt;
        logic [7:0] a;
        cnt = -1;
        a   = 8'd0;
        rif.map_valid = 1'b0;
        rif.map_data  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rif.map_valid = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    rif.map_valid = 1'b1;
                    rif.map_data  = walls[a];
                    cnt = -1;
                end
            end
            if (rif.map_rd === 1'b1) begin
                rd_log.push_back(rif.map_addr);
                if (!rom_mute) begin
                    a   = rif.map_addr;
                    cnt = rom_delay + 1;
                end
            end
            if (moved === 1'b1) mv_cnt++;
            if (busy === 1'b1) busy_seen = 1'b1;
        end
    end

    // Behavioural model of one pulse sequence: x check first, then y on the updated x.
    task automatic model_move(input logic [3:0] p);
        int dx, dy, nx, ny, ox, oy;
        bit any;
        exp_q.delete();
        m_moved = 1'b0;
        if (m_goal) return;
        ox = m_x;
        oy = m_y;
        any = 1'b0;
        dx = (p[1] && !p[0]) ? 1 : ((p[0] && !p[1]) ? -1 : 0);
        dy = (p[3] && !p[2]) ? 1 : ((p[2] && !p[3]) ? -1 : 0);
        nx = m_x + dx;
        ny = m_y + dy;
        if (dx != 0 && nx >= 0 && nx <= 15) begin
            any = 1'b1;
            exp_q.push_back(8'(m_y * 16 + nx));
            if (!rom_mute && !walls[m_y * 16 + nx]) m_x = nx;
        end
        if (dy != 0 && ny >= 0 && ny <= 15) begin
            any = 1'b1;
            exp_q.push_back(8'(ny * 16 + m_x));
            if (!rom_mute && !walls[ny * 16 + m_x]) m_y = ny;
        end
        if (any) begin
            if (m_x != ox || m_y != oy) begin
                m_moved = 1'b1;
                if (m_cnt < 65535) m_cnt++;
            end
            if (m_x == 15 && m_y == 15) m_goal = 1'b1;
        end
    endtask

    task automatic model_reset();
        m_x = 0; m_y = 0; m_cnt = 0; m_goal = 1'b0; m_moved = 1'b0;
    endtask

    function automatic bit reads_match();
        if (rd_log.size() != exp_q.size()) return 1'b0;
        foreach (rd_log[i]) if (rd_log[i] !== exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_obs();
        rd_log.delete();
        mv_cnt = 0;
        busy_seen = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy !== 1'b0) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles, want 0", busy, n);
        end
        @(negedge clk);
    endtask

    task automatic do_move(input logic [3:0] p);
        model_move(p);
        clear_obs();
        @(negedge clk);
        move_pulses = p;
        @(posedge clk);
        #1;
        move_pulses = 4'd0;
        wait_idle();
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        model_reset();
    endtask

    task automatic clear_walls();
        foreach (walls[i]) walls[i] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        restart = 1'b0;
        move_pulses = 4'd0;
        rom_mute = 1'b0;
        rom_delay = 1;
        clear_walls();
        model_reset();
        #22;
        tests++;
        if ({x_pos, y_pos, moved, goal_reached, busy, move_count, rif.map_rd, rif.map_addr} !== '0) begin
            fails++;
            $display("FAIL reset_state: pos=(%0d,%0d) mv=%b goal=%b busy=%b cnt=%0d rd=%b addr=%h, want all 0",
                     x_pos, y_pos, moved, goal_reached, busy, move_count, rif.map_rd, rif.map_addr);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_step();
        int rd_k [$];
        int mv_k [$];
        int busy_low;
        logic [7:0] addr_seen;
        rom_delay = 1;
        model_move(4'b0010);
        clear_obs();
        busy_low = -1;
        addr_seen = 8'hxx;
        @(negedge clk);
        move_pulses = 4'b0010;
        @(posedge clk);
        #1;
        move_pulses = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (rif.map_rd === 1'b1) begin rd_k.push_back(k); addr_seen = rif.map_addr; end
            if (moved === 1'b1) mv_k.push_back(k);
            if (busy !== 1'b1 && busy_low < 0) busy_low = k;
            @(posedge clk);
            #1;
        end
        tests++;
        if (rd_k.size() != 1 || rd_k[0] != 0 || addr_seen !== 8'h01) begin
            fails++;
            $display("FAIL step_read: reads=%0d first_k=%0d addr=%h, want 1 read at k=0 addr 01",
                     rd_k.size(), (rd_k.size() > 0) ? rd_k[0] : -1, addr_seen);
        end
        tests++;
        if (mv_k.size() != 1 || mv_k[0] != 3) begin
            fails++;
            $display("FAIL step_moved: pulses=%0d first_k=%0d, want 1 at k=3",
                     mv_k.size(), (mv_k.size() > 0) ? mv_k[0] : -1);
        end
        tests++;
        if (busy_low != 4) begin
            fails++;
            $display("FAIL step_busy: busy low at k=%0d, want 4", busy_low);
        end
        tests++;
        if (x_pos !== 4'd1 || y_pos !== 4'd0 || move_count !== 16'd1 || x_pos !== 4'(m_x)) begin
            fails++;
            $display("FAIL step_pos: pos=(%0d,%0d) cnt=%0d, want (1,0) cnt=1", x_pos, y_pos, move_count);
        end
        @(negedge clk);
    endtask

    task automatic test_wall();
        walls[8'h11] = 1'b1;
        do_move(4'b1000);
        tests++;
        if (x_pos !== 4'd1 || y_pos !== 4'd0 || mv_cnt != 0 || move_count !== 16'd1) begin
            fails++;
            $display("FAIL wall_block: pos=(%0d,%0d) moved=%0d cnt=%0d, want (1,0) 0 1",
                     x_pos, y_pos, mv_cnt, move_count);
        end
        tests++;
        if (rd_log.size() != 1 || rd_log[0] !== 8'h11) begin
            fails++;
            $display("FAIL wall_addr: reads=%0d first=%h, want 1 read of 11",
                     rd_log.size(), (rd_log.size() > 0) ? rd_log[0] : 8'hxx);
        end
    endtask

    task automatic test_edges();
        do_restart();
        do_move(4'b0101);
        tests++;
        if (rd_log.size() != 0 || busy_seen || x_pos !== 4'd0 || y_pos !== 4'd0) begin
            fails++;
            $display("FAIL edge_offgrid: reads=%0d busy_seen=%b pos=(%0d,%0d), want 0 0 (0,0)",
                     rd_log.size(), busy_seen, x_pos, y_pos);
        end
        do_move(4'b0011);
        tests++;
        if (rd_log.size() != 0 || busy_seen) begin
            fails++;
            $display("FAIL edge_conflict: reads=%0d busy_seen=%b, want 0 0", rd_log.size(), busy_seen);
        end
    endtask

    task automatic test_diagonal();
        clear_walls();
        rom_delay = 0;
        repeat (3) do_move(4'b0010);
        repeat (3) do_move(4'b1000);
        walls[8'h44] = 1'b1;
        do_move(4'b1010);
        tests++;
        if (rd_log.size() != 2 || rd_log[0] !== 8'h34 || rd_log[1] !== 8'h44) begin
            fails++;
            $display("FAIL diag_order: reads=%0d, want 34 then 44", rd_log.size());
        end
        tests++;
        if (x_pos !== 4'd4 || y_pos !== 4'd3 || mv_cnt != 1 || move_count !== 16'(m_cnt)) begin
            fails++;
            $display("FAIL diag_pos: pos=(%0d,%0d) moved=%0d cnt=%0d, want (4,3) 1 %0d",
                     x_pos, y_pos, mv_cnt, move_count, m_cnt);
        end
    endtask

    task automatic test_back_to_back();
        model_move(4'b0010);
        clear_obs();
        @(negedge clk);
        move_pulses = 4'b0010;
        @(negedge clk);
        move_pulses = 4'b1000;
        @(negedge clk);
        move_pulses = 4'd0;
        #1;
        wait_idle();
        tests++;
        if (x_pos !== 4'd5 || y_pos !== 4'd3 || rd_log.size() != 1 || rd_log[0] !== 8'h35) begin
            fails++;
            $display("FAIL b2b_drop: pos=(%0d,%0d) reads=%0d, want (5,3) one read of 35",
                     x_pos, y_pos, rd_log.size());
        end
    endtask

    task automatic test_timeout();
        int blen;
        rom_mute = 1'b1;
        model_move(4'b0010);
        clear_obs();
        @(negedge clk);
        move_pulses = 4'b0010;
        @(posedge clk);
        #1;
        move_pulses = 4'd0;
        blen = 0;
        while (busy === 1'b1 && blen < 100) begin
            blen++;
            @(posedge clk);
            #1;
        end
        tests++;
        if (blen != TMO + 2 || x_pos !== 4'd5 || y_pos !== 4'd3 || mv_cnt != 0) begin
            fails++;
            $display("FAIL timeout_len: busy_cycles=%0d pos=(%0d,%0d) moved=%0d, want %0d (5,3) 0",
                     blen, x_pos, y_pos, mv_cnt, TMO + 2);
        end
        // restart in the middle of a wait
        @(negedge clk);
        move_pulses = 4'b0010;
        @(negedge clk);
        move_pulses = 4'd0;
        repeat (3) @(negedge clk);
        do_restart();
        tests++;
        if (busy !== 1'b0 || x_pos !== 4'd0 || y_pos !== 4'd0 || move_count !== 16'd0) begin
            fails++;
            $display("FAIL restart_midwait: busy=%b pos=(%0d,%0d) cnt=%0d, want 0 (0,0) 0",
                     busy, x_pos, y_pos, move_count);
        end
        rom_mute = 1'b0;
        do_move(4'b0010);
        // async reset in the middle of a wait
        rom_mute = 1'b1;
        @(negedge clk);
        move_pulses = 4'b0010;
        @(negedge clk);
        move_pulses = 4'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if ({x_pos, y_pos, moved, goal_reached, busy, move_count, rif.map_rd, rif.map_addr} !== '0) begin
            fails++;
            $display("FAIL reset_midwait: pos=(%0d,%0d) busy=%b cnt=%0d addr=%h, want all 0",
                     x_pos, y_pos, busy, move_count, rif.map_addr);
        end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        rom_mute = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_goal();
        do_restart();
        clear_walls();
        rom_delay = 0;
        repeat (15) do_move(4'b0010);
        repeat (15) do_move(4'b1000);
        tests++;
        if (goal_reached !== 1'b1 || x_pos !== 4'd15 || y_pos !== 4'd15 || move_count !== 16'd30) begin
            fails++;
            $display("FAIL goal_set: goal=%b pos=(%0d,%0d) cnt=%0d, want 1 (15,15) 30",
                     goal_reached, x_pos, y_pos, move_count);
        end
        do_move(4'b0101);
        tests++;
        if (rd_log.size() != 0 || busy_seen || x_pos !== 4'd15 || y_pos !== 4'd15) begin
            fails++;
            $display("FAIL goal_lock: reads=%0d busy_seen=%b pos=(%0d,%0d), want 0 0 (15,15)",
                     rd_log.size(), busy_seen, x_pos, y_pos);
        end
        do_restart();
        tests++;
        if (goal_reached !== 1'b0 || x_pos !== 4'd0 || y_pos !== 4'd0 || move_count !== 16'd0) begin
            fails++;
            $display("FAIL goal_restart: goal=%b pos=(%0d,%0d) cnt=%0d, want 0 (0,0) 0",
                     goal_reached, x_pos, y_pos, move_count);
        end
    endtask

    task automatic test_random();
        logic [3:0] p;
        do_restart();
        foreach (walls[i]) walls[i] = ($urandom_range(0, 4) == 0);
        walls[0] = 1'b0;
        for (int it = 0; it < 60; it++) begin
            p = 4'($urandom_range(0, 15));
            rom_delay = $urandom_range(0, 3);
            rom_mute = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) do_restart();
            do_move(p);
            tests++;
            if (x_pos !== 4'(m_x) || y_pos !== 4'(m_y) || move_count !== 16'(m_cnt) ||
                goal_reached !== m_goal || mv_cnt != int'(m_moved) || !reads_match()) begin
                fails++;
                $display("FAIL rand_%0d: p=%b pos=(%0d,%0d) cnt=%0d goal=%b moved=%0d reads=%0d, want (%0d,%0d) %0d %b %0d %0d",
                         it, p, x_pos, y_pos, move_count, goal_reached, mv_cnt, rd_log.size(),
                         m_x, m_y, m_cnt, m_goal, m_moved, exp_q.size());
            end
        end
        rom_mute = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_wall();
        test_edges();
        test_diagonal();
        test_back_to_back();
        test_timeout();
        test_goal();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule
